// File: rtl/sdram_fifo_param_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_fifo_param_if
// Description : Handshake/data bundle between a FIFO user and the
//               parametrised SDRAM data-path FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_fifo_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic                  clearFifo;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] dataIn;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  empty;
  logic                  full;
  logic                  almostEmpty;
  logic                  almostFull;
  logic [ADDR_WIDTH:0]   fillLevel;
  logic                  overflow;
  logic                  underflow;

  // User side: issues requests, observes data and status.
  modport master (
    output clearFifo, push, pop, dataIn,
    input  dataOut, empty, full, almostEmpty, almostFull,
    input  fillLevel, overflow, underflow
  );

  // FIFO side: accepts requests, drives data and status.
  modport slave (
    input  clearFifo, push, pop, dataIn,
    output dataOut, empty, full, almostEmpty, almostFull,
    output fillLevel, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/sdram_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sdram_fifo_param
// Description : Parametrised synchronous FIFO with registered fill level,
//               almost-full/almost-empty thresholds, sticky overflow and
//               underflow flags and optional show-ahead read mode.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_fifo_param #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 9,
  parameter int ALMOST_FULL_LEVEL  = (2**ADDR_WIDTH) - 4,
  parameter int ALMOST_EMPTY_LEVEL = 4,
  parameter int SHOWAHEAD          = 0
) (
  input  wire logic             clock,
  input  wire logic             reset,
  sdram_fifo_param_if.slave     bus
);

  localparam int                c_DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_LVL_FULL = (ADDR_WIDTH+1)'(c_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_LVL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] c_LVL_AF   = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] c_LVL_AE   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_LEVEL);
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Reject parameter sets the FIFO cannot honour.
  generate
    if ((DATA_WIDTH < 1) || (DATA_WIDTH > 128) ||
        (ADDR_WIDTH < 2) || (ADDR_WIDTH > 12) ||
        (ALMOST_EMPTY_LEVEL < 0) || (ALMOST_EMPTY_LEVEL > c_DEPTH) ||
        (ALMOST_FULL_LEVEL < 0) || (ALMOST_FULL_LEVEL > c_DEPTH) ||
        (SHOWAHEAD < 0) || (SHOWAHEAD > 1)) begin : g_param_error
      $error("sdram_fifo_param: parameter out of range");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_aempty;
  logic                  r_afull;
  logic                  r_ovf;
  logic                  r_udf;
  logic [DATA_WIDTH-1:0] r_dout;

  logic                  w_pop_acc;
  logic                  w_push_acc;
  logic                  w_wr_en;
  logic [ADDR_WIDTH:0]   w_level_nxt;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_inc;

  // Accept rules: a pop frees a slot, so push-while-full is legal with a pop.
  assign w_pop_acc    = bus.pop & ~r_empty;
  assign w_push_acc   = bus.push & (~r_full | w_pop_acc);
  assign w_wr_en      = w_push_acc & ~bus.clearFifo;
  assign w_rd_ptr_inc = r_rd_ptr + c_PTR_ONE;

  // Fill level after this edge; flags are derived from it so they track fillLevel.
  always_comb begin
    w_level_nxt = r_level;
    if (w_push_acc && !w_pop_acc) begin
      w_level_nxt = r_level + c_LVL_ONE;
    end else if (!w_push_acc && w_pop_acc) begin
      w_level_nxt = r_level - c_LVL_ONE;
    end
  end

  // Storage array: written on accepted push, never reset.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= bus.dataIn;
    end
  end

  // Pointers, level and status flags; clear has priority over push/pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (bus.clearFifo) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop_acc)  r_rd_ptr <= w_rd_ptr_inc;
      r_level  <= w_level_nxt;
      r_empty  <= (w_level_nxt == '0);
      r_full   <= (w_level_nxt == c_LVL_FULL);
      r_aempty <= (w_level_nxt <= c_LVL_AE);
      r_afull  <= (w_level_nxt >= c_LVL_AF);
      if (bus.push && !w_push_acc) r_ovf <= 1'b1;
      if (bus.pop && r_empty)      r_udf <= 1'b1;
    end
  end

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      // Head register: always holds the oldest word while not empty.
      // A word entering an empty FIFO (or replacing the last word) is loaded
      // straight from dataIn into this register, so no memory read-after-write
      // hazard exists and dataOut stays purely registered.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_dout <= '0;
        end else if (bus.clearFifo) begin
          r_dout <= '0;
        end else if (w_pop_acc) begin
          if (r_level == c_LVL_ONE) begin
            if (w_push_acc) r_dout <= bus.dataIn;
          end else begin
            r_dout <= r_mem[w_rd_ptr_inc];
          end
        end else if (r_empty && w_push_acc) begin
          r_dout <= bus.dataIn;
        end
      end
    end else begin : g_registered
      // Registered read: popped word appears the edge after acceptance.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_dout <= '0;
        end else if (bus.clearFifo) begin
          r_dout <= '0;
        end else if (w_pop_acc) begin
          r_dout <= r_mem[r_rd_ptr];
        end
      end
    end
  endgenerate

  assign bus.dataOut     = r_dout;
  assign bus.empty       = r_empty;
  assign bus.full        = r_full;
  assign bus.almostEmpty = r_aempty;
  assign bus.almostFull  = r_afull;
  assign bus.fillLevel   = r_level;
  assign bus.overflow    = r_ovf;
  assign bus.underflow   = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_sdram_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_fifo_param
// Description : Self-checking bench; a registered-read and a show-ahead FIFO
//               receive identical stimulus and are compared to a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_fifo_param;

  localparam int c_DEPTH = 8;
  localparam int c_AF    = 4;
  localparam int c_AE    = 2;

  logic clock;
  logic reset;

  sdram_fifo_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus0 ();
  sdram_fifo_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus1 ();

  sdram_fifo_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(3), .ALMOST_FULL_LEVEL(c_AF),
    .ALMOST_EMPTY_LEVEL(c_AE), .SHOWAHEAD(0)
  ) u_dut_reg (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  sdram_fifo_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(3), .ALMOST_FULL_LEVEL(c_AF),
    .ALMOST_EMPTY_LEVEL(c_AE), .SHOWAHEAD(1)
  ) u_dut_sa (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [31:0] q[$];
  logic        m_ovf;
  logic        m_udf;
  logic [31:0] m_dout_reg;
  logic [31:0] m_dout_sa;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
    m_dout_reg = '0;
    m_dout_sa  = '0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, "/lvl_reg"},   32'(bus0.fillLevel),   32'(n));
    check({tag, "/lvl_sa"},    32'(bus1.fillLevel),   32'(n));
    check({tag, "/empty_reg"}, 32'(bus0.empty),       32'(n == 0));
    check({tag, "/empty_sa"},  32'(bus1.empty),       32'(n == 0));
    check({tag, "/full_reg"},  32'(bus0.full),        32'(n == c_DEPTH));
    check({tag, "/full_sa"},   32'(bus1.full),        32'(n == c_DEPTH));
    check({tag, "/ae_reg"},    32'(bus0.almostEmpty), 32'(n <= c_AE));
    check({tag, "/ae_sa"},     32'(bus1.almostEmpty), 32'(n <= c_AE));
    check({tag, "/af_reg"},    32'(bus0.almostFull),  32'(n >= c_AF));
    check({tag, "/af_sa"},     32'(bus1.almostFull),  32'(n >= c_AF));
    check({tag, "/ovf_reg"},   32'(bus0.overflow),    32'(m_ovf));
    check({tag, "/ovf_sa"},    32'(bus1.overflow),    32'(m_ovf));
    check({tag, "/udf_reg"},   32'(bus0.underflow),   32'(m_udf));
    check({tag, "/udf_sa"},    32'(bus1.underflow),   32'(m_udf));
    check({tag, "/dout_reg"},  bus0.dataOut,          m_dout_reg);
    check({tag, "/dout_sa"},   bus1.dataOut,          m_dout_sa);
  endtask

  // One clock step: drive both FIFOs, advance the model, check after the edge.
  // Called at posedge+1 so inputs settle well before the next edge.
  task automatic step(input string tag, input logic p, input logic r,
                      input logic [31:0] d, input logic clr);
    logic pa;
    logic wa;
    bus0.push = p;   bus0.pop = r;   bus0.dataIn = d;   bus0.clearFifo = clr;
    bus1.push = p;   bus1.pop = r;   bus1.dataIn = d;   bus1.clearFifo = clr;
    if (clr) begin
      model_reset();
    end else begin
      pa = r && (q.size() > 0);
      wa = p && ((q.size() < c_DEPTH) || pa);
      if (p && !wa)          m_ovf = 1'b1;
      if (r && q.size() == 0) m_udf = 1'b1;
      if (pa) m_dout_reg = q.pop_front();
      if (wa) q.push_back(d);
      if (q.size() > 0) m_dout_sa = q[0];
    end
    @(posedge clock);
    #1;
    bus0.push = 1'b0; bus0.pop = 1'b0; bus0.clearFifo = 1'b0;
    bus1.push = 1'b0; bus1.pop = 1'b0; bus1.clearFifo = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int peak;
    logic [31:0] d;
    logic p;
    logic r;
    logic c;

    bus0.push = 1'b0; bus0.pop = 1'b0; bus0.dataIn = '0; bus0.clearFifo = 1'b0;
    bus1.push = 1'b0; bus1.pop = 1'b0; bus1.dataIn = '0; bus1.clearFifo = 1'b0;
    model_reset();

    // Reset state
    reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check_all("reset");
    reset = 1'b1;

    // Fill with 0x11..0x88
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, 32'(i * 8'h11), 1'b0);
    check("fill/level8", 32'(bus0.fillLevel), 32'd8);
    check("fill/full",   32'(bus0.full),      32'd1);
    check("fill/af",     32'(bus0.almostFull), 32'd1);

    // Push on full alone -> overflow; then push 0x99 with pop
    step("ovf", 1'b1, 1'b0, 32'hDEAD, 1'b0);
    check("ovf/flag", 32'(bus0.overflow), 32'd1);
    step("push_pop_full", 1'b1, 1'b1, 32'h99, 1'b0);
    check("push_pop_full/dout", bus0.dataOut, 32'h11);

    // Drain 8 words, then one extra pop for underflow
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, '0, 1'b0);
    check("drain/last", bus0.dataOut, 32'h99);
    step("udf", 1'b0, 1'b1, '0, 1'b0);
    check("udf/flag", 32'(bus0.underflow), 32'd1);
    check("udf/dout", bus0.dataOut, 32'h99);

    // Pointer wrap: 20 words interleaved
    step("clr0", 1'b0, 1'b0, '0, 1'b1);
    peak = 0;
    step("wrap", 1'b1, 1'b0, 32'd1, 1'b0);
    for (int i = 2; i <= 20; i++) begin
      step("wrap", 1'b1, 1'b1, 32'(i), 1'b0);
      if (int'(bus0.fillLevel) > peak) peak = int'(bus0.fillLevel);
    end
    step("wrap_last", 1'b0, 1'b1, '0, 1'b0);
    check("wrap/final_dout", bus0.dataOut, 32'd20);
    check("wrap/peak_le2", 32'(peak <= 2), 32'd1);

    // Show-ahead: write to empty, then push and pop together
    step("sa_a5", 1'b1, 1'b0, 32'hA5, 1'b0);
    check("sa_a5/dout", bus1.dataOut, 32'hA5);
    step("sa_5a", 1'b1, 1'b1, 32'h5A, 1'b0);
    check("sa_5a/dout", bus1.dataOut, 32'h5A);
    check("sa_5a/lvl", 32'(bus1.fillLevel), 32'd1);

    // clearFifo with level 5 and overflow set; push/pop ignored that cycle
    for (int i = 0; i < 8; i++) step("cl_fill", 1'b1, 1'b0, $urandom, 1'b0);
    for (int i = 0; i < 3; i++) step("cl_pop", 1'b0, 1'b1, '0, 1'b0);
    check("cl/lvl5", 32'(bus0.fillLevel), 32'd5);
    step("clear", 1'b1, 1'b1, 32'h1234, 1'b1);
    check("clear/lvl0", 32'(bus0.fillLevel), 32'd0);

    // Asynchronous reset between edges
    for (int i = 0; i < 4; i++) step("ar_fill", 1'b1, 1'b0, $urandom, 1'b0);
    step("ar_pop", 1'b0, 1'b1, '0, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_all("after_reset");

    // Randomized traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      d = $urandom;
      if (i < 200) p = ($urandom_range(0, 99) < 65);
      else         p = ($urandom_range(0, 99) < 35);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 63) == 0);
      step("rand", p, r, d, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_fifo_param.md
Name: sdram_fifo_param

Overview:
Parametrised synchronous FIFO for the SDRAM controller data paths. It buffers read-return words, and optionally write-data words, between the SDRAM state machine and the bus side. It extends the fixed 512x32 read FIFO with:
- configurable width and depth
- a registered fill level
- programmable almost-full/almost-empty thresholds
- sticky overflow/underflow flags
- a selectable show-ahead (first-word-fall-through) read mode

Storage is an internal dual-port array with synchronous read, written and read on the rising edge of `clock` only.

Parameters:
DATA_WIDTH, 32, word width in bits (1..128)
ADDR_WIDTH, 9, depth = 2**ADDR_WIDTH words (2..12)
ALMOST_FULL_LEVEL, 2**ADDR_WIDTH-4, almostFull asserted when fillLevel >= this
ALMOST_EMPTY_LEVEL, 4, almostEmpty asserted when fillLevel <= this
SHOWAHEAD, 0, 0 = registered read (data 1 cycle after pop); 1 = head word presented while not empty

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
clearFifo  in  1  synchronous clear, same effect as reset on FIFO state
push  in  1  write request
pop  in  1  read request
dataIn  in  DATA_WIDTH  write data
dataOut  out  DATA_WIDTH  read data
empty  out  1  FIFO empty
full  out  1  FIFO full
almostEmpty  out  1  fillLevel <= ALMOST_EMPTY_LEVEL
almostFull  out  1  fillLevel >= ALMOST_FULL_LEVEL
fillLevel  out  ADDR_WIDTH+1  number of stored words, 0..2**ADDR_WIDTH
overflow  out  1  sticky: push attempted while full and not accepted
underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (reset=0, asynchronous):
  - pointers = 0, fillLevel = 0
  - empty=1, full=0, almostEmpty=1, almostFull=0
  - overflow=0, underflow=0, dataOut=0
  - Memory contents are not reset.
- clearFifo=1 at a rising edge has the same effect as reset on all outputs and pointers, and has priority over push/pop in that cycle.
- Accept rules:
  - Pop is accepted iff pop=1 and empty=0.
  - Push is accepted iff push=1 and (full=0 or pop is accepted in the same cycle). Push-while-full with a simultaneous pop is legal and leaves the level unchanged.
- Pointers are ADDR_WIDTH bits and wrap modulo depth with no special case. An accepted push writes dataIn at the write pointer.
- fillLevel: +1 on push-only, -1 on pop-only, unchanged on both or neither. It is registered and updates on the same edge as the pointers.
- Flags:
  - empty, full, almostEmpty and almostFull are registered and derived from the next fillLevel, so they are consistent with fillLevel every cycle.
  - full = (fillLevel == 2**ADDR_WIDTH).
  - empty = (fillLevel == 0).
- overflow and underflow:
  - overflow is set by push=1 while not accepted; underflow is set by pop=1 while empty=1.
  - Once set, each holds until reset or clearFifo.
- Latency:
  - A word pushed at edge N makes empty=0 after edge N.
  - The earliest pop of that word is accepted at edge N+1.
- SHOWAHEAD=0:
  - The popped word appears on dataOut after the edge following acceptance (pop accepted at edge M, dataOut valid from edge M+1).
  - dataOut holds its value when no pop is accepted.
- SHOWAHEAD=1:
  - Whenever empty=0, dataOut equals the oldest stored word.
  - An accepted pop at edge M presents the next word (if any) after edge M.
  - When empty=1, dataOut holds its last value.
  - The implementation must handle write-to-empty and read-after-write to the same address. The required approach is a head/output register with bypass, with no combinational path from dataIn to dataOut.
- Thresholds: requires 0 <= ALMOST_EMPTY_LEVEL and ALMOST_FULL_LEVEL <= 2**ADDR_WIDTH. Out-of-range values are a parameter error, caught with an elaboration-time check.
- Reset asserted mid-burst: the FIFO is empty immediately (asynchronously) and no partially accepted operation survives.

Test Plan:
- Reset, then fill (DATA_WIDTH=32, ADDR_WIDTH=3, SHOWAHEAD=0):
  - Assert reset=0, release, then push 0x11..0x88 on 8 consecutive cycles.
  - After the 8th edge: fillLevel=8, full=1, almostFull=1 (threshold 4), empty=0, overflow=0.
- Overflow and push-on-full with pop:
  - From full, push=1 alone: overflow=1, fillLevel stays 8.
  - Then push 0x99 with pop=1: fillLevel stays 8; dataOut=0x11 the next cycle.
- Drain, wrap and underflow:
  - Pop 8 times: dataOut sequence is 0x22..0x88 then 0x99; empty=1 after the last pop.
  - An extra pop sets underflow=1 and leaves dataOut=0x99.
- Pointer wrap (ADDR_WIDTH=3):
  - Interleave push/pop over 20 words with values 1..20.
  - Popped order is exactly 1..20 and fillLevel never exceeds 2.
- SHOWAHEAD=1:
  - Push 0xA5 into an empty FIFO: one edge later empty=0 and dataOut=0xA5 with no pop issued.
  - Push 0x5A and pop on the same edge: dataOut=0x5A after the edge and fillLevel=1.
- clearFifo and asynchronous reset:
  - With fillLevel=5 and overflow=1, pulse clearFifo: next edge gives fillLevel=0, empty=1, overflow=0, and push/pop in that cycle are ignored.
  - Drop reset between edges: outputs clear immediately, before the next clock edge.
